// File: rtl/two_fsk_pkg.sv
// rtl/two_fsk_pkg.sv - shared 2-FSK tone/state types, default timing constants and period classifier
package two_fsk_pkg;

   typedef enum logic [1:0] {
      TONE0    = 2'd0,
      TONE1    = 2'd1,
      TONE_INV = 2'd2
   } tone_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2
   } state_e;

   localparam int DEF_F1_PERIOD = 8;
   localparam int DEF_F2_PERIOD = 4;
   localparam int DEF_TOL       = 1;
   localparam int DEF_SYM_LEN   = 32;
   localparam int DEF_LOCK_N    = 2;
   localparam int DEF_MAX_PER   = 31;
   localparam int DEF_PER_W     = 6;

   // Tone 1 is tested first; the legal parameter range keeps the two windows disjoint.
   function automatic tone_e classify(input int p, input int f1, input int f2, input int tol);
      int d1;
      int d2;
      d1 = (p > f1) ? (p - f1) : (f1 - p);
      d2 = (p > f2) ? (p - f2) : (f2 - p);
      if (d1 <= tol) begin
         return TONE1;
      end
      if (d2 <= tol) begin
         return TONE0;
      end
      return TONE_INV;
   endfunction

endpackage

// File: rtl/two_fsk_demod_if.sv
// rtl/two_fsk_demod_if.sv - FSK line input and decided-bit outputs of the demodulator
interface two_fsk_demod_if;
   logic       din;
   logic       bit_out;
   logic       bit_valid;
   logic       carrier_ok;
   logic [7:0] err_cnt;

   modport master (output din, input bit_out, bit_valid, carrier_ok, err_cnt);
   modport slave  (input din, output bit_out, bit_valid, carrier_ok, err_cnt);
endinterface

// File: rtl/fsk_period_meter.sv
// rtl/fsk_period_meter.sv - synchronizer, rising-edge period counter, timeout and tone classifier
module fsk_period_meter
   import two_fsk_pkg::*;
#(
   parameter int F1_PERIOD = DEF_F1_PERIOD,
   parameter int F2_PERIOD = DEF_F2_PERIOD,
   parameter int TOL       = DEF_TOL,
   parameter int MAX_PER   = DEF_MAX_PER,
   parameter int PER_W     = DEF_PER_W
)
(
   input  logic  clk,
   input  logic  reset,
   input  logic  i_din,
   output logic  o_rise,
   output logic  o_class_valid,
   output tone_e o_class,
   output logic  o_timeout
);

   localparam logic [PER_W-1:0] MAX_CNT = PER_W'(MAX_PER);

   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic [PER_W-1:0] r_per_cnt;
   logic             r_have_edge;
   logic             w_rise;
   logic             w_timeout;

   assign w_rise    = r_s2 & ~r_s3;
   assign w_timeout = (r_per_cnt == MAX_CNT) & ~w_rise;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1        <= 1'b0;
         r_s2        <= 1'b0;
         r_s3        <= 1'b0;
         r_per_cnt   <= '0;
         r_have_edge <= 1'b0;
      end else begin
         r_s1 <= i_din;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         // Counter parks at MAX_CNT after a timeout until the carrier returns.
         if (w_rise) begin
            r_per_cnt   <= '0;
            r_have_edge <= 1'b1;
         end else if (w_timeout) begin
            r_have_edge <= 1'b0;
         end else begin
            r_per_cnt <= r_per_cnt + 1'b1;
         end
      end
   end

   assign o_rise        = w_rise;
   assign o_class_valid = w_rise & r_have_edge;
   assign o_class       = classify(int'(r_per_cnt) + 1, F1_PERIOD, F2_PERIOD, TOL);
   assign o_timeout     = w_timeout;

endmodule

// File: rtl/two_fsk_demod.sv
// rtl/two_fsk_demod.sv - 2-FSK demodulator top: lock FSM, symbol timing and error counter
module two_fsk_demod
   import two_fsk_pkg::*;
#(
   parameter int F1_PERIOD = DEF_F1_PERIOD,
   parameter int F2_PERIOD = DEF_F2_PERIOD,
   parameter int TOL       = DEF_TOL,
   parameter int SYM_LEN   = DEF_SYM_LEN,
   parameter int LOCK_N    = DEF_LOCK_N,
   parameter int MAX_PER   = DEF_MAX_PER,
   parameter int PER_W     = DEF_PER_W
)
(
   input  logic           clk,
   input  logic           reset,
   two_fsk_demod_if.slave bus
);

   localparam int SYM_W  = $clog2(SYM_LEN);
   localparam int LOCK_W = $clog2(LOCK_N + 1);
   localparam logic [SYM_W-1:0]  SYM_LAST = SYM_W'(SYM_LEN - 1);
   localparam logic [SYM_W-1:0]  SYM_PRE  = SYM_W'(SYM_LEN / 2 - 1);
   localparam logic [LOCK_W-1:0] LOCK_PRE = LOCK_W'(LOCK_N - 1);

   logic              w_rise;
   logic              w_class_valid;
   tone_e             w_class;
   logic              w_timeout;

   state_e            r_state;
   tone_e             r_cur_tone;
   logic [LOCK_W-1:0] r_lock_cnt;
   logic [SYM_W-1:0]  r_sym_cnt;
   logic [7:0]        r_err_cnt;
   logic              r_bit_out;
   logic              r_bit_valid;
   logic              r_carrier_ok;

   fsk_period_meter #(
      .F1_PERIOD (F1_PERIOD),
      .F2_PERIOD (F2_PERIOD),
      .TOL       (TOL),
      .MAX_PER   (MAX_PER),
      .PER_W     (PER_W)
   ) u_meter (
      .clk           (clk),
      .reset         (reset),
      .i_din         (bus.din),
      .o_rise        (w_rise),
      .o_class_valid (w_class_valid),
      .o_class       (w_class),
      .o_timeout     (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cur_tone   <= TONE0;
         r_lock_cnt   <= '0;
         r_sym_cnt    <= '0;
         r_err_cnt    <= '0;
         r_bit_out    <= 1'b0;
         r_bit_valid  <= 1'b0;
         r_carrier_ok <= 1'b0;
      end else begin
         r_bit_valid <= 1'b0;
         if (w_timeout) begin
            r_state      <= IDLE;
            r_carrier_ok <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_rise) begin
                     r_state    <= ACQ;
                     r_lock_cnt <= '0;
                  end
               end
               ACQ: begin
                  if (w_class_valid) begin
                     if (w_class == TONE_INV) begin
                        r_lock_cnt <= '0;
                     end else if (r_lock_cnt == LOCK_PRE) begin
                        r_state      <= LOCK;
                        r_carrier_ok <= 1'b1;
                        r_cur_tone   <= w_class;
                        r_sym_cnt    <= '0;
                        r_lock_cnt   <= '0;
                     end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                     end
                  end
               end
               LOCK: begin
                  if (w_class_valid && (w_class == TONE_INV)) begin
                     r_state      <= ACQ;
                     r_carrier_ok <= 1'b0;
                     r_lock_cnt   <= '0;
                     if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                     end
                  end else if (w_class_valid && (w_class != r_cur_tone)) begin
                     // Tone change marks a symbol boundary; it overrides any strobe due now.
                     r_cur_tone <= w_class;
                     r_sym_cnt  <= '0;
                  end else begin
                     r_sym_cnt <= (r_sym_cnt == SYM_LAST) ? '0 : r_sym_cnt + 1'b1;
                     // Strobe is registered so it is visible while sym_cnt sits at mid-symbol.
                     if (r_sym_cnt == SYM_PRE) begin
                        r_bit_valid <= 1'b1;
                        r_bit_out   <= (r_cur_tone == TONE1);
                     end
                  end
               end
               default: begin
                  r_state      <= IDLE;
                  r_carrier_ok <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.bit_out    = r_bit_out;
   assign bus.bit_valid  = r_bit_valid;
   assign bus.carrier_ok = r_carrier_ok;
   assign bus.err_cnt    = r_err_cnt;

endmodule
